// File: rtl/mutex_requester_pkg.sv
// Shared types and helpers for the mutex requester agent.
// State encoding is fixed so it can be matched against arbiter-side debug views.
package mutex_requester_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StOwn     = 2'd2,
    StRelease = 2'd3
  } state_e;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned acc;
    res = 0;
    acc = 1;
    while (acc < value) begin
      acc = acc << 1;
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/mutex_requester_if.sv
// Local-write, arbiter and shared-bus signals of one mutex requester client.
// master = the requester agent, slave = its environment (source, arbiter, bus sink).
interface mutex_requester_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              request;
  logic              grant;
  logic [DATA_W-1:0] bus_data;
  logic              bus_valid;
  logic              bus_ready;
  logic              busy;

  modport master (
    input  in_data, in_valid, grant, bus_ready,
    output in_ready, request, bus_data, bus_valid, busy
  );

  modport slave (
    output in_data, in_valid, grant, bus_ready,
    input  in_ready, request, bus_data, bus_valid, busy
  );

endinterface

// File: rtl/mutex_requester_fifo.sv
// Show-ahead FIFO: rdata always presents the oldest word while not empty.
// Pointers wrap naturally because DEPTH is a power of two.
module mutex_requester_fifo
  import mutex_requester_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned PtrW  = clog2(DEPTH),
  localparam int unsigned CntW  = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CntW-1:0]   count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wptr_q;
  logic [PtrW-1:0]   rptr_q;
  logic [CntW-1:0]   count_q;
  logic [CntW-1:0]   count_d;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only words below count are ever observable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/mutex_requester.sv
// Client agent for the priority mutex arbiter: buffers local words, requests the lock,
// streams a bounded burst, then backs off so lower-priority clients can win arbitration.
module mutex_requester
  import mutex_requester_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned GAP       = 2
) (
  input logic              clk,
  input logic              rst_n,
  mutex_requester_if.master bus
);

  localparam int unsigned CntW   = clog2(DEPTH + 1);
  localparam int unsigned BurstW = clog2(MAX_BURST + 1);
  localparam int unsigned GapW   = clog2(GAP + 1);

  state_e            state_q;
  state_e            state_d;
  logic [BurstW-1:0] burst_q;
  logic [BurstW-1:0] burst_d;
  logic [GapW-1:0]   gap_q;
  logic [GapW-1:0]   gap_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CntW-1:0]   fifo_count;
  logic              push;
  logic              beat;

  assign push          = bus.in_valid & bus.in_ready;
  assign beat          = bus.bus_valid & bus.bus_ready;
  assign bus.in_ready  = ~fifo_full;
  assign bus.bus_valid = (state_q == StOwn) & bus.grant & ~fifo_empty;
  assign bus.request   = (state_q == StReq) | (state_q == StOwn);
  assign bus.busy      = (state_q != StIdle);

  mutex_requester_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (bus.in_data),
    .pop   (beat),
    .rdata (bus.bus_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    gap_d   = gap_q;
    case (state_q)
      StIdle: begin
        // A grant lingering from our last ownership must clear before re-requesting.
        if (fifo_count != '0 && !bus.grant) state_d = StReq;
      end
      StReq: begin
        if (bus.grant) begin
          state_d = StOwn;
          burst_d = '0;
        end
      end
      StOwn: begin
        if (beat) burst_d = burst_q + BurstW'(1);
        // Grant loss is an abort; nothing is lost since words pop only on a beat.
        if (!bus.grant || fifo_empty ||
            (beat && burst_q == BurstW'(MAX_BURST - 1))) begin
          state_d = StRelease;
          gap_d   = GapW'(GAP - 1);
        end
      end
      StRelease: begin
        if (gap_q == '0) state_d = StIdle;
        else             gap_d   = gap_q - GapW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      burst_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_mutex_requester.sv
// Two requesters on a modelled 2-line priority mutex arbiter; a negedge monitor checks
// every handshake against per-client expected-word queues and burst bookkeeping.
module tb_mutex_requester;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned GAP       = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic arb_en;
  logic arb_kill;
  int   owner_q;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mutex_requester_if #(.DATA_W(DATA_W)) ifc0 ();
  mutex_requester_if #(.DATA_W(DATA_W)) ifc1 ();

  mutex_requester #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST), .GAP(GAP)
  ) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc0)
  );

  mutex_requester #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST), .GAP(GAP)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc1)
  );

  // Arbiter: client 0 has priority; the owner keeps the lock until its request drops.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               owner_q <= 0;
    else if (arb_kill)                        owner_q <= 0;
    else if (owner_q == 1 && !ifc0.request)   owner_q <= 0;
    else if (owner_q == 2 && !ifc1.request)   owner_q <= 0;
    else if (owner_q == 0 && arb_en) begin
      if (ifc0.request)      owner_q <= 1;
      else if (ifc1.request) owner_q <= 2;
    end
  end
  assign ifc0.grant = (owner_q == 1);
  assign ifc1.grant = (owner_q == 2);

  // Reference model state.
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  int         beat_cyc0 [$];
  int         burst_log [$];
  int         beats_n [2] = '{0, 0};
  int         cur_beats [2];
  logic       prev_grant [2];
  logic       prev_req [2];
  logic       hold [2];
  logic [7:0] hold_data [2];
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int c, input logic in_valid, input logic in_ready,
                     input logic [7:0] in_data, input logic bus_valid, input logic bus_ready,
                     input logic [7:0] bus_data, input logic grant, input logic request);
    int         occ;
    logic [7:0] head;
    occ = (c == 0) ? exp_q0.size() : exp_q1.size();
    check("in_ready_vs_occupancy", in_ready, occ < DEPTH);
    if (bus_valid) check("valid_needs_grant_and_request", {grant, request}, 2'b11);
    if (hold[c] && bus_valid) check("stalled_data_stable", bus_data, hold_data[c]);
    if (request && !prev_req[c]) check("request_rises_with_grant_low", grant, 1'b0);
    if (bus_valid && bus_ready) begin
      check("beat_has_pending_word", occ != 0, 1'b1);
      if (occ != 0) begin
        head = (c == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check("beat_data_order", bus_data, head);
      end
      cur_beats[c]++;
      beats_n[c]++;
      if (c == 0) beat_cyc0.push_back(cyc);
      check("burst_within_limit", cur_beats[c] <= MAX_BURST, 1'b1);
    end
    if (in_valid && in_ready) begin
      if (c == 0) exp_q0.push_back(in_data);
      else        exp_q1.push_back(in_data);
    end
    hold[c]      = bus_valid & ~bus_ready;
    hold_data[c] = bus_data;
    if (prev_grant[c] && !grant) begin
      if (cur_beats[c] > 0) burst_log.push_back(c * 100 + cur_beats[c]);
      cur_beats[c] = 0;
    end
    prev_grant[c] = grant;
    prev_req[c]   = request;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
      for (int c = 0; c < 2; c++) begin
        cur_beats[c]  = 0;
        prev_grant[c] = 1'b0;
        prev_req[c]   = 1'b0;
        hold[c]       = 1'b0;
      end
    end else begin
      mon(0, ifc0.in_valid, ifc0.in_ready, ifc0.in_data, ifc0.bus_valid, ifc0.bus_ready,
          ifc0.bus_data, ifc0.grant, ifc0.request);
      mon(1, ifc1.in_valid, ifc1.in_ready, ifc1.in_data, ifc1.bus_valid, ifc1.bus_ready,
          ifc1.bus_data, ifc1.grant, ifc1.request);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [7:0] d);
    ifc0.in_valid = 1'b1;
    ifc0.in_data  = d;
    tick();
    ifc0.in_valid = 1'b0;
  endtask

  task automatic wait_beats(input int c, input int target, input string tag);
    for (int i = 0; i < 300; i++) begin
      if (beats_n[c] >= target) break;
      tick();
    end
    check(tag, beats_n[c] >= target, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (!ifc0.busy && !ifc1.busy && exp_q0.size() == 0 && exp_q1.size() == 0) break;
      tick();
    end
    check(tag, {ifc0.busy, ifc1.busy, exp_q0.size() == 0, exp_q1.size() == 0}, 4'b0011);
  endtask

  task automatic expect_bursts(input string tag, input int n, input int e0, input int e1,
                               input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    check({tag, "_count"}, burst_log.size(), n);
    for (int i = 0; i < n && i < burst_log.size(); i++) check(tag, burst_log[i], e[i]);
  endtask

  initial begin
    int t0;
    int c0;
    int sz;
    int n;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b0;
    arb_en = 1'b0;
    arb_kill = 1'b0;
    ifc0.in_valid = 1'b0; ifc0.in_data = '0; ifc0.bus_ready = 1'b0;
    ifc1.in_valid = 1'b0; ifc1.in_data = '0; ifc1.bus_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("reset_request", ifc0.request, 1'b0);
    check("reset_bus_valid", ifc0.bus_valid, 1'b0);
    check("reset_busy", ifc0.busy, 1'b0);
    check("reset_in_ready", ifc0.in_ready, 1'b1);

    // Basic: three words, grant withheld two cycles.
    ifc0.bus_ready = 1'b1;
    push0(8'h11);
    check("basic_request_not_yet", ifc0.request, 1'b0);
    push0(8'h22);
    check("basic_request_after_one_cycle", ifc0.request, 1'b1);
    push0(8'h33);
    repeat (2) tick();
    arb_en = 1'b1;
    t0 = beats_n[0];
    wait_beats(0, t0 + 3, "basic_three_beats");
    sz = beat_cyc0.size();
    check("basic_beats_back_to_back", beat_cyc0[sz-1] - beat_cyc0[sz-3], 2);
    for (int i = 0; i < 20 && ifc0.request; i++) tick();
    check("basic_request_dropped", ifc0.request, 1'b0);
    for (int g = 0; g < GAP; g++) begin
      check("basic_release_busy", ifc0.busy, 1'b1);
      tick();
    end
    check("basic_idle_after_gap", {ifc0.busy, ifc0.request}, 2'b00);

    // Latency with the arbiter already enabled.
    push0(8'h5A);
    c0 = cyc;
    wait_beats(0, beats_n[0] + 1, "latency_beat");
    check("latency_first_beat", beat_cyc0[beat_cyc0.size()-1] - c0, 3);
    wait_idle("latency_idle");

    // Burst limit: six words give 4 + 2.
    arb_en = 1'b0;
    for (int i = 0; i < 6; i++) push0(8'hA0 + 8'(i));
    burst_log.delete();
    arb_en = 1'b1;
    wait_beats(0, beats_n[0] + 6, "burst_six_beats");
    wait_idle("burst_idle");
    expect_bursts("burst_split", 2, 4, 2, 0, 0);

    // Backpressure during a burst.
    arb_en = 1'b0;
    for (int i = 0; i < 4; i++) push0(8'hB0 + 8'(i));
    burst_log.delete();
    arb_en = 1'b1;
    t0 = beats_n[0] + 4;
    for (int i = 0; i < 60 && beats_n[0] < t0; i++) begin
      ifc0.bus_ready = pat[i % 4];
      tick();
    end
    ifc0.bus_ready = 1'b1;
    wait_idle("bp_idle");
    expect_bursts("bp_single_burst", 1, 4, 0, 0, 0);

    // FIFO full: nine words, no grant.
    arb_en = 1'b0;
    for (int i = 0; i < 8; i++) push0(8'hC0 + 8'(i));
    check("full_in_ready_low", ifc0.in_ready, 1'b0);
    ifc0.in_valid = 1'b1;
    ifc0.in_data  = 8'hC8;
    repeat (3) tick();
    check("full_held_off", {ifc0.in_ready, ifc0.request}, 2'b01);
    burst_log.delete();
    arb_en = 1'b1;
    for (int i = 0; i < 30 && !ifc0.in_ready; i++) tick();
    check("full_space_after_pop", ifc0.in_ready, 1'b1);
    tick();
    ifc0.in_valid = 1'b0;
    wait_idle("full_idle");
    expect_bursts("full_bursts", 3, 4, 4, 1, 0);
    check("full_drained_in_ready", ifc0.in_ready, 1'b1);

    // Contention: both clients loaded with eight words.
    arb_en = 1'b0;
    ifc1.bus_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ifc0.in_valid = 1'b1; ifc0.in_data = 8'h40 + 8'(i);
      ifc1.in_valid = 1'b1; ifc1.in_data = 8'h80 + 8'(i);
      tick();
    end
    ifc0.in_valid = 1'b0;
    ifc1.in_valid = 1'b0;
    burst_log.delete();
    arb_en = 1'b1;
    for (int i = 0; i < 20 && !ifc0.grant; i++) tick();
    for (int i = 0; i < 20 && ifc0.request; i++) tick();
    n = 0;
    for (int i = 0; i < 20 && !ifc1.grant; i++) begin
      tick();
      n++;
    end
    check("handoff_within_gap_plus_2", ifc1.grant && n <= GAP + 2, 1'b1);
    wait_idle("contention_idle");
    expect_bursts("contention_alternate", 4, 4, 104, 4, 104);

    // Grant aborted after one beat; all words still delivered in order.
    arb_en = 1'b0;
    for (int i = 0; i < 4; i++) push0(8'hD0 + 8'(i));
    arb_en = 1'b1;
    t0 = beats_n[0];
    wait_beats(0, t0 + 1, "abort_first_beat");
    arb_kill = 1'b1;
    tick();
    arb_kill = 1'b0;
    wait_beats(0, t0 + 4, "abort_all_beats");
    wait_idle("abort_idle");

    // Asynchronous reset mid-burst.
    arb_en = 1'b0;
    for (int i = 0; i < 6; i++) push0(8'hE0 + 8'(i));
    arb_en = 1'b1;
    wait_beats(0, beats_n[0] + 2, "reset_mid_two_beats");
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {ifc0.request, ifc0.bus_valid, ifc0.busy}, 3'b000);
    tick();
    rst_n = 1'b1;
    t0 = beats_n[0];
    for (int i = 0; i < 4; i++) begin
      check("post_reset_quiet", {ifc0.in_ready, ifc0.bus_valid, ifc0.busy}, 3'b100);
      tick();
    end
    check("post_reset_no_beat", beats_n[0], t0);

    // Randomized traffic on both clients.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 60; i++) begin
        ifc0.in_valid  = 1'($urandom_range(0, 1));
        ifc0.in_data   = 8'($urandom);
        ifc1.in_valid  = ($urandom_range(0, 2) == 0);
        ifc1.in_data   = 8'($urandom);
        ifc0.bus_ready = ($urandom_range(0, 3) != 0);
        ifc1.bus_ready = ($urandom_range(0, 3) != 0);
        arb_en         = ($urandom_range(0, 7) != 0);
        tick();
      end
      ifc0.in_valid = 1'b0;
      ifc1.in_valid = 1'b0;
      ifc0.bus_ready = 1'b1;
      ifc1.bus_ready = 1'b1;
      arb_en = 1'b1;
      wait_idle("random_drain");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
